// File: rtl/rip_fetch.sv
// Instruction fetch stage: drives the fetch address to a one-cycle synchronous
// instruction memory and presents the returned word, with its PC, to decode.
module rip_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] if_dout,
  output logic                  id_valid,
  output logic [DATA_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_inst,
  output logic                  misalign_err
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                    id_valid_q, id_valid_d;
  logic                    misalign_q, misalign_d;

  // A redirect must be able to fetch its target even while decode is stalled.
  assign if_ready     = ~stall | redirect;
  assign pc           = pc_q;
  assign id_pc        = fetch_pc_q;
  assign id_valid     = id_valid_q;
  assign id_inst      = id_valid_q ? if_dout : NOP_INST;
  assign misalign_err = misalign_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = redirect ? BUBBLE : RUN;
      RUN:     state_d = redirect ? BUBBLE : RUN;
      BUBBLE:  state_d = redirect ? BUBBLE : RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    id_valid_d = id_valid_q;
    misalign_d = misalign_q;

    if (redirect) begin
      pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_q + DATA_WIDTH'(4);
    end

    if (if_ready) begin
      fetch_pc_d = pc_q;
    end

    // The word returned after a redirect edge belongs to the killed path.
    if (redirect) begin
      id_valid_d = 1'b0;
    end else if (!stall) begin
      id_valid_d = (state_d == RUN);
    end

    if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      id_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      id_valid_q <= id_valid_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_rip_fetch.sv
// Bench for rip_fetch: two instances (default and high RESET_PC) driven by the
// same directed stimulus, checked against a transaction-level fetch model.
module tb_rip_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic        if_ready [2];
  logic [31:0] pc       [2];
  logic [31:0] if_dout  [2];
  logic        id_valid [2];
  logic [31:0] id_pc    [2];
  logic [31:0] id_inst  [2];
  logic        mis      [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rip_fetch u_dut0 (
    .clk(clk), .rstn(rstn), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .if_ready(if_ready[0]), .pc(pc[0]),
    .if_dout(if_dout[0]), .id_valid(id_valid[0]), .id_pc(id_pc[0]),
    .id_inst(id_inst[0]), .misalign_err(mis[0])
  );

  rip_fetch #(.RESET_PC(RPC1)) u_dut1 (
    .clk(clk), .rstn(rstn), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .if_ready(if_ready[1]), .pc(pc[1]),
    .if_dout(if_dout[1]), .id_valid(id_valid[1]), .id_pc(id_pc[1]),
    .id_inst(id_inst[1]), .misalign_err(mis[1])
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hC0DE_0001;
  endfunction

  // Synchronous instruction memories: output holds while the port is disabled.
  initial begin
    if_dout[0] = 32'h0;
    if_dout[1] = 32'h0;
  end
  always @(posedge clk) begin
    if (if_ready[0]) if_dout[0] <= mem_word(pc[0]);
    if (if_ready[1]) if_dout[1] <= mem_word(pc[1]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: next fetch address, and the instruction currently presented to decode.
  logic [31:0] m_next [2];
  logic [31:0] m_idpc [2];
  logic        m_vld  [2];
  logic        m_mis  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        m_next[i] = (i == 0) ? 32'h0 : RPC1;
        m_vld[i]  = 1'b0;
        m_mis[i]  = 1'b0;
      end else if (redirect) begin
        m_vld[i]  = 1'b0;
        m_next[i] = redirect_pc & ~32'h3;
        if (redirect_pc[1:0] != 2'b00) m_mis[i] = 1'b1;
      end else if (!stall) begin
        m_vld[i]  = 1'b1;
        m_idpc[i] = m_next[i];
        m_next[i] = m_next[i] + 32'd4;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("if_ready", {31'b0, if_ready[i]}, {31'b0, ~stall | redirect});
      chk("pc", pc[i], m_next[i]);
      chk("id_valid", {31'b0, id_valid[i]}, {31'b0, m_vld[i]});
      chk("misalign_err", {31'b0, mis[i]}, {31'b0, m_mis[i]});
      if (m_vld[i]) begin
        chk("id_pc", id_pc[i], m_idpc[i]);
        chk("id_inst", id_inst[i], mem_word(m_idpc[i]));
      end else begin
        chk("id_inst_nop", id_inst[i], NOP);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_pc0", pc[0], 32'h0);
    chk("rst_pc1", pc[1], RPC1);
    chk("rst_vld", {31'b0, id_valid[0]}, 32'h0);
    chk("rst_inst", id_inst[0], NOP);
    stall = 1'b1; #1;
    chk("rst_ifready_stall", {31'b0, if_ready[0]}, 32'h0);
    stall = 1'b0;

    // Reset release and in-order fetch, including PC wrap on instance 1
    rstn = 1'b1;
    cyc();
    chk("boot_vld", {31'b0, id_valid[0]}, 32'h1);
    chk("boot_pc", id_pc[0], 32'h0);
    chk("boot_inst", id_inst[0], mem_word(32'h0));
    chk("boot_pc1", id_pc[1], 32'hFFFF_FFF8);
    cyc();
    chk("seq_pc", id_pc[0], 32'h4);
    chk("seq_inst", id_inst[0], mem_word(32'h4));
    chk("seq_pc1", id_pc[1], 32'hFFFF_FFFC);
    cyc();
    chk("seq_pc8", id_pc[0], 32'h8);
    chk("wrap_pc1", id_pc[1], 32'h0);

    // Three-cycle stall at id_pc=8
    stall = 1'b1; #1;
    chk("stall_ifready", {31'b0, if_ready[0]}, 32'h0);
    repeat (3) begin
      cyc();
      chk("stall_idpc", id_pc[0], 32'h8);
      chk("stall_inst", id_inst[0], mem_word(32'h8));
      chk("stall_pc", pc[0], 32'hC);
    end
    stall = 1'b0;
    cyc();
    chk("unstall_idpc", id_pc[0], 32'hC);
    cyc();
    chk("pre_redir_idpc", id_pc[0], 32'h10);

    // Redirect to 0x100
    redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    chk("redir_vld", {31'b0, id_valid[0]}, 32'h0);
    chk("redir_inst", id_inst[0], NOP);
    redirect = 1'b0;
    cyc();
    chk("redir_tgt_vld", {31'b0, id_valid[0]}, 32'h1);
    chk("redir_tgt_pc", id_pc[0], 32'h100);

    // Redirect together with stall
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h200; #1;
    chk("rs_ifready", {31'b0, if_ready[0]}, 32'h1);
    cyc();
    chk("rs_vld", {31'b0, id_valid[0]}, 32'h0);
    redirect = 1'b0; stall = 1'b0;
    cyc();
    chk("rs_tgt_pc", id_pc[0], 32'h200);

    // Back-to-back redirects ending on a misaligned target
    redirect = 1'b1; redirect_pc = 32'h300;
    cyc();
    chk("b2b_vld0", {31'b0, id_valid[0]}, 32'h0);
    redirect_pc = 32'h103;
    cyc();
    chk("b2b_vld1", {31'b0, id_valid[0]}, 32'h0);
    chk("mis_set", {31'b0, mis[0]}, 32'h1);
    redirect = 1'b0;
    cyc();
    chk("mis_tgt_pc", id_pc[0], 32'h100);
    cyc(); cyc();
    chk("mis_sticky", {31'b0, mis[0]}, 32'h1);

    // Mixed stall/redirect pattern, checked by the model every cycle
    for (int i = 0; i < 40; i++) begin
      stall       = (i % 5 == 2) || (i % 7 == 3);
      redirect    = (i % 9 == 4) || (i == 30) || (i == 31);
      redirect_pc = 32'h400 + i * 32'h44 + (i % 3);
      cyc();
    end
    stall = 1'b0; redirect = 1'b0;
    cyc();

    // Reset mid-stall
    stall = 1'b1;
    cyc();
    rstn = 1'b0; #1;
    chk("rst_mid_vld0", {31'b0, id_valid[0]}, 32'h0);
    chk("rst_mid_vld1", {31'b0, id_valid[1]}, 32'h0);
    chk("rst_mid_pc1", pc[1], RPC1);
    chk("rst_mid_mis", {31'b0, mis[0]}, 32'h0);
    cyc();
    stall = 1'b0; rstn = 1'b1;
    cyc();
    chk("restart_pc1", id_pc[1], 32'hFFFF_FFF8);
    chk("restart_vld1", {31'b0, id_valid[1]}, 32'h1);

    // Reset mid-bubble
    redirect = 1'b1; redirect_pc = 32'h80;
    cyc();
    redirect = 1'b0; rstn = 1'b0; #1;
    chk("rst_bub_vld", {31'b0, id_valid[0]}, 32'h0);
    chk("rst_bub_pc", pc[0], 32'h0);
    cyc();
    rstn = 1'b1;
    cyc();
    chk("restart_pc0", id_pc[0], 32'h0);
    chk("restart_inst0", id_inst[0], mem_word(32'h0));
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
